// File: rtl/vec_sweep_pkg.sv
// Purpose: shared types, constants and golden model for the vector sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vec_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int NUM_VEC = 8;

    // Golden {D,E} of the minimized stage for vector idx = {a,b,c}.
    function automatic logic [1:0] exp_de(input logic [2:0] idx);
        logic a;
        logic b;
        logic c;
        {a, b, c} = idx;
        return {(a & b) | ~c, ~c};
    endfunction

endpackage

// File: rtl/vec_sweep_seq.sv
// Purpose: drives all eight {a,b,c} vectors into the gate stage, captures D/E, counts mismatches.
// Latency: busy for 8*HOLD_CYCLES cycles after start, done pulses one cycle later.
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise.
module vec_sweep_seq
    import vec_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        a,
    output logic        b,
    output logic        c,
    input  logic        d_in,
    input  logic        e_in,
    output logic [15:0] truth,
    output logic [3:0]  mismatch_cnt
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_VEC - 1);

    state_t         r_state;
    logic [2:0]     r_idx;
    logic [HW-1:0]  r_hold;
    logic           r_busy;
    logic           r_done;
    logic [15:0]    r_truth;
    logic [3:0]     r_mcnt;

    logic [1:0]     w_obs;
    logic           w_miss;
    logic           w_sample;

    // The stage output is valid in the same cycle the vector is presented.
    assign w_obs    = {d_in, e_in};
    assign w_miss   = (w_obs != exp_de(r_idx));
    assign w_sample = (r_hold == '0);

    // Sequencer: state, vector index, hold timer and result capture in one register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_truth <= 16'h0000;
            r_mcnt  <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= DRIVE;
                        r_idx   <= 3'd0;
                        r_hold  <= HOLD_LD;
                        r_busy  <= 1'b1;
                        r_truth <= 16'h0000;
                        r_mcnt  <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (w_sample) begin
                        r_truth[{r_idx, 1'b0} +: 2] <= w_obs;
                        if (w_miss) begin
                            r_mcnt <= r_mcnt + 4'd1;
                        end
                        if (r_idx == LAST_IDX) begin
                            // Vector lines return to 000 while done is shown.
                            r_state <= FIN;
                            r_idx   <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + 3'd1;
                            r_hold <= HOLD_LD;
                        end
                    end else begin
                        r_hold <= r_hold - {{(HW-1){1'b0}}, 1'b1};
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= 3'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign {a, b, c}    = r_idx;
    assign truth        = r_truth;
    assign mismatch_cnt = r_mcnt;

endmodule

// File: tb/tb_vec_sweep_seq.sv
module tb_vec_sweep_seq;

    localparam int H0 = 2;
    localparam int H1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       r_start;
    logic       sel;          // 0: dut0 (H0), 1: dut1 (H1)
    logic       d_tie0;
    logic       e_force7;
    logic [7:0] dmask;
    logic [7:0] emask;

    int n_cmp = 0;
    int n_err = 0;

    logic        start0, start1;
    logic        busy0, done0, a0, b0, c0, d_in0, e_in0;
    logic        busy1, done1, a1, b1, c1, d_in1, e_in1;
    logic [15:0] truth0, truth1;
    logic [3:0]  mcnt0, mcnt1;

    assign start0 = r_start & ~sel;
    assign start1 = r_start & sel;

    // Gate stage D = AB + C', E = C', with optional fault injection.
    assign d_in0 = d_tie0 ? 1'b0 : (((a0 & b0) | ~c0) ^ dmask[{a0, b0, c0}]);
    assign e_in0 = (e_force7 && ({a0, b0, c0} == 3'd7)) ? 1'b1 : (~c0 ^ emask[{a0, b0, c0}]);
    assign d_in1 = d_tie0 ? 1'b0 : (((a1 & b1) | ~c1) ^ dmask[{a1, b1, c1}]);
    assign e_in1 = (e_force7 && ({a1, b1, c1} == 3'd7)) ? 1'b1 : (~c1 ^ emask[{a1, b1, c1}]);

    vec_sweep_seq #(.HOLD_CYCLES(H0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .a(a0), .b(b0), .c(c0), .d_in(d_in0), .e_in(e_in0),
        .truth(truth0), .mismatch_cnt(mcnt0)
    );

    vec_sweep_seq #(.HOLD_CYCLES(H1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .a(a1), .b(b1), .c(c1), .d_in(d_in1), .e_in(e_in1),
        .truth(truth1), .mismatch_cnt(mcnt1)
    );

    logic        s_busy, s_done;
    logic [2:0]  s_abc;
    logic [15:0] s_truth;
    logic [3:0]  s_mcnt;
    assign s_busy  = sel ? busy1  : busy0;
    assign s_done  = sel ? done1  : done0;
    assign s_abc   = sel ? {a1, b1, c1} : {a0, b0, c0};
    assign s_truth = sel ? truth1 : truth0;
    assign s_mcnt  = sel ? mcnt1  : mcnt0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truth table and mismatch count from the boolean equations and fault settings.
    task automatic model(output logic [15:0] t, output logic [3:0] m);
        logic [2:0] kv;
        logic gd, ge, d, e;
        t = 16'h0;
        m = 4'd0;
        for (int k = 0; k < 8; k++) begin
            kv = k[2:0];
            gd = (kv[2] & kv[1]) | ~kv[0];
            ge = ~kv[0];
            d  = d_tie0 ? 1'b0 : (gd ^ dmask[k]);
            e  = (e_force7 && k == 7) ? 1'b1 : (ge ^ emask[k]);
            t[2*k+1] = d;
            t[2*k]   = e;
            if (d != gd || e != ge) m = m + 4'd1;
        end
    endtask

    // One sweep on the selected DUT; timing and final capture are checked.
    task automatic run_sweep(input int h, input bit hold_start, input string tag);
        logic [15:0] et;
        logic [3:0]  em;
        int busy_cnt = 0, busy_err = 0, done_cnt = 0, done_cyc = 0, abc_err = 0, done2 = 0;
        logic [2:0] eabc;
        model(et, em);
        @(negedge clk) r_start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) r_start = 1'b0;
        for (int n = 1; n <= 8*h + 2; n++) begin
            if (s_busy) busy_cnt++;
            if (s_busy !== (n <= 8*h)) busy_err++;
            if (s_done) begin done_cnt++; done_cyc = n; end
            eabc = (n <= 8*h) ? 3'((n - 1) / h) : 3'd0;
            if (s_abc !== eabc) abc_err++;
            if (n < 8*h + 2) begin @(posedge clk); #1; end
        end
        check({tag, ".busy_cycles"}, busy_cnt, 8*h);
        check({tag, ".busy_shape"}, busy_err, 0);
        check({tag, ".done_count"}, done_cnt, 1);
        check({tag, ".done_cycle"}, done_cyc, 8*h + 1);
        check({tag, ".abc_seq"}, abc_err, 0);
        check({tag, ".truth"}, s_truth, et);
        check({tag, ".mcnt"}, s_mcnt, em);
        if (hold_start) begin
            @(posedge clk); #1;
            check({tag, ".restart_busy"}, s_busy, 1'b1);
            check({tag, ".restart_truth_clr"}, s_truth, 16'h0);
            check({tag, ".restart_mcnt_clr"}, s_mcnt, 4'd0);
            r_start = 1'b0;
            for (int n = 2; n <= 8*h + 2; n++) begin
                @(posedge clk); #1;
                if (s_done) done2++;
            end
            check({tag, ".second_done_count"}, done2, 1);
            check({tag, ".second_truth"}, s_truth, et);
            check({tag, ".second_mcnt"}, s_mcnt, em);
        end
    endtask

    initial begin
        int dcnt;
        rst_n    = 1'b0;
        r_start  = 1'b0;
        sel      = 1'b0;
        d_tie0   = 1'b0;
        e_force7 = 1'b0;
        dmask    = 8'h00;
        emask    = 8'h00;
        #22;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset.dut0", {busy0, done0, a0, b0, c0, truth0, mcnt0}, 0);
        check("reset.dut1", {busy1, done1, a1, b1, c1, truth1, mcnt1}, 0);

        // Correct stage, both hold settings.
        run_sweep(H0, 1'b0, "h2_good");
        check("h2_good.B333", truth0, 16'hB333);
        sel = 1'b1;
        run_sweep(H1, 1'b0, "h1_good");
        check("h1_good.B333", truth1, 16'hB333);
        sel = 1'b0;

        // D tied low.
        d_tie0 = 1'b1;
        run_sweep(H0, 1'b0, "d_tie0");
        check("d_tie0.1111", truth0, 16'h1111);
        check("d_tie0.cnt5", mcnt0, 4'd5);
        d_tie0 = 1'b0;

        // Start held through the sweep and FIN.
        run_sweep(H0, 1'b1, "held");

        // Async reset during vector 4 (cycles 9..10 at hold 2).
        @(negedge clk) r_start = 1'b1;
        @(posedge clk); #1;
        r_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort.vec4", {a0, b0, c0}, 3'd4);
        #2 rst_n = 1'b0;
        #1;
        check("abort.outputs", {busy0, done0, a0, b0, c0, truth0, mcnt0}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 24; n++) begin
            @(posedge clk); #1;
            if (done0) dcnt++;
        end
        check("abort.no_done", dcnt, 0);
        run_sweep(H0, 1'b0, "after_abort");
        check("after_abort.B333", truth0, 16'hB333);

        // E forced high on vector 7.
        e_force7 = 1'b1;
        run_sweep(H0, 1'b0, "e7");
        check("e7.F333", truth0, 16'hF333);
        check("e7.cnt1", mcnt0, 4'd1);
        e_force7 = 1'b0;

        // Random fault patterns on both DUTs.
        for (int i = 0; i < 6; i++) begin
            sel   = 1'($urandom_range(0, 1));
            dmask = 8'($urandom);
            emask = 8'($urandom);
            if (i == 5) begin dmask = 8'hFF; emask = 8'hFF; end
            run_sweep(sel ? H1 : H0, 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_sweep_seq.md
# vec_sweep_seq

Upstream stimulus sequencer and result capture for the three-input minimized gate stage (inputs A, B, C; outputs D = AB + C′, E = C′). On a start request it drives all eight {A,B,C} combinations in ascending order and holds each for a programmable number of cycles. It samples the stage's D/E outputs at the end of each hold, builds a 16-bit captured truth table, and counts mismatches against the golden equations. It sits directly in front of the combinational stage and consumes that stage's outputs.

## Interface
Parameters:
- HOLD_CYCLES, 2, cycles each vector is held before sampling; legal range 1..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; sampled only in IDLE.
- busy  out  1  high while vectors are being driven.
- done  out  1  one-cycle pulse when a sweep completes.
- a, b, c  out  1 each  vector driven to the gate stage.
- d_in, e_in  in  1 each  D and E returned from the gate stage.
- truth  out  16  captured results; bits [2k+1] = D and [2k] = E for vector k = {a,b,c}.
- mismatch_cnt  out  4  count of vectors whose {D,E} differs from golden, range 0..8.

## Operation
- Reset value of every output: busy=0, done=0, a=b=c=0, truth=16'h0000, mismatch_cnt=0.
- FSM states: IDLE, DRIVE, FIN.
- IDLE:
  - start=1 moves the FSM to DRIVE.
  - On that transition: idx=0, hold counter=HOLD_CYCLES-1, truth cleared, mismatch_cnt cleared.
- DRIVE:
  - busy=1; {a,b,c}=idx.
  - Hold counter decrements every cycle.
  - In the cycle where the counter is 0: write {d_in,e_in} into truth[2*idx+1:2*idx]. If this differs from golden {(a&b)|~c, ~c}, increment mismatch_cnt.
  - After that cycle: if idx==7, go to FIN. Otherwise idx+1 and reload the counter.
- FIN: busy=0, done=1 for exactly one cycle, {a,b,c}=000, then return to IDLE.
- While returning to IDLE, truth and mismatch_cnt hold their values until the next accepted start.
- start is ignored in DRIVE and in FIN, with no queuing.
- a, b, c and busy are registered outputs. d_in and e_in are assumed to settle combinationally within the same cycle.

## Timing
- Start is accepted at clock edge E0. Cycle n is the cycle following edge E0+n-1.
- Vector k is driven during cycles k·HOLD_CYCLES+1 .. (k+1)·HOLD_CYCLES and sampled at the edge ending its last cycle.
- busy is high for exactly 8·HOLD_CYCLES cycles. done is high in cycle 8·HOLD_CYCLES+1.
- For HOLD_CYCLES=1, every DRIVE cycle is a sample cycle.
- The earliest re-start is accepted at the edge ending the first IDLE cycle after FIN.
- Asynchronous reset mid-sweep forces every output to its reset value immediately. No done is emitted for an aborted sweep.
- Reset deassertion is synchronized by the environment. The block is in IDLE on the first edge after deassertion.
- mismatch_cnt is never wrapped; its maximum is 8, which fits in 4 bits.

## Structure
- Package vec_sweep_pkg contains:
  - the state enum (IDLE/DRIVE/FIN);
  - NUM_VEC=8;
  - golden function exp_de(idx[2:0]) returning the 2-bit value {(a&b)|~c, ~c}.
- The hold counter width is $clog2(HOLD_CYCLES+1), derived in the module.
- No sub-module is required. FSM, index counter, hold counter and capture logic all live in vec_sweep_seq.
- The bench instantiates the gate stage between a,b,c and d_in,e_in.

## Test plan
- Reset then idle 5 cycles -> all outputs 0; start pulse with correct stage, HOLD_CYCLES=2 -> busy high 16 cycles, done in cycle 17, truth=16'hB333, mismatch_cnt=0.
- Same with HOLD_CYCLES=1 -> busy 8 cycles, done in cycle 9, truth=16'hB333.
- d_in tied 0, e_in from correct stage -> truth=16'h1111, mismatch_cnt=5.
- start held high continuously through sweep and FIN -> exactly one done per sweep. The second sweep's start is accepted in IDLE, and truth is cleared only at that acceptance.
- rst_n pulsed low during vector 4 -> all outputs 0 asynchronously and no done. A following start completes normally with truth=16'hB333.
- e_in forced to 1 for vector 7 only -> truth=16'hF333, mismatch_cnt=1.
